// File: rtl/display_puntuacion_pkg.sv
// Shared definitions for the score display: FSM encoding, segment codes,
// default parameters and the double-dabble nibble correction.
package display_puntuacion_pkg;

    localparam int SCORE_W         = 14;
    localparam int BCD_W           = 16;
    localparam int NUM_DIG         = 4;
    localparam int SCORE_MAX_DEF   = 9999;
    localparam int REFRESH_DIV_DEF = 50000;
    // One shift per input bit.
    localparam int SHIFT_CYCLES    = SCORE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the doubling shift, so it is pre-biased by 3.
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/display_puntuacion_decodificador_7seg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes go dark.
module decodificador_7seg
    import display_puntuacion_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [6:0] segmentos_o
);

    // Pure lookup, no state.
    always_comb begin
        segmentos_o = SEG_BLANK;
        case (digito_i)
            4'd0:    segmentos_o = SEG_0;
            4'd1:    segmentos_o = SEG_1;
            4'd2:    segmentos_o = SEG_2;
            4'd3:    segmentos_o = SEG_3;
            4'd4:    segmentos_o = SEG_4;
            4'd5:    segmentos_o = SEG_5;
            4'd6:    segmentos_o = SEG_6;
            4'd7:    segmentos_o = SEG_7;
            4'd8:    segmentos_o = SEG_8;
            4'd9:    segmentos_o = SEG_9;
            default: segmentos_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_puntuacion.sv
// Four-digit multiplexed score display. A small FSM converts the binary
// score to BCD with a sequential double-dabble (one bit per cycle) and
// publishes all four digits at once when it finishes, so the scan logic
// never sees a half-converted value. The scan side walks the anodes at
// REFRESH_DIV cycles per digit and blanks leading zeros.
module display_puntuacion
    import display_puntuacion_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEF,
    parameter int SCORE_MAX   = SCORE_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SCORE_W-1:0]   puntuacion,
    output logic [NUM_DIG-1:0]   anodos,
    output logic [6:0]           segmentos,
    output logic                 busy
);

    localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]      ITER_LAST = 4'(SHIFT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SAT_VAL = SCORE_W'(SCORE_MAX);

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    logic load_en, shift_en, done_en;

    logic [SCORE_W-1:0]            last_val_q, last_val_d;
    logic [SCORE_W-1:0]            bin_q, bin_d;
    logic [BCD_W-1:0]              bcd_q, bcd_d;
    logic [BCD_W-1:0]              bcd_adj;
    logic [3:0]                    iter_q, iter_d;
    logic [NUM_DIG-1:0][3:0]       dig_q, dig_d;
    logic                          busy_q, busy_d;
    logic [SCORE_W-1:0]            sat_val;

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: IDLE re-compares against the last raw input it accepted,
    // everything after LOAD runs to completion regardless of the input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (puntuacion != last_val_q) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: if (iter_q == ITER_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: one enable per datapath action.
    always_comb begin
        load_en  = 1'b0;
        shift_en = 1'b0;
        done_en  = 1'b0;
        case (state_q)
            ST_LOAD:  load_en  = 1'b1;
            ST_SHIFT: shift_en = 1'b1;
            ST_DONE:  done_en  = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble datapath
    // ------------------------------------------------------------------
    assign sat_val = (puntuacion > SAT_VAL) ? SAT_VAL : puntuacion;

    // Per-nibble correction applied before every shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            bcd_adj[i*4 +: 4] = dd_adjust(bcd_q[i*4 +: 4]);
        end
    end

    // Datapath next-state. last_val keeps the raw input so a constant
    // out-of-range score does not look like a change every IDLE cycle.
    always_comb begin
        last_val_d = last_val_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        dig_d      = dig_q;
        busy_d     = busy_q;
        if (load_en) begin
            last_val_d = puntuacion;
            bin_d      = sat_val;
            bcd_d      = '0;
            iter_d     = '0;
            busy_d     = 1'b1;
        end
        if (shift_en) begin
            bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
            bin_d  = {bin_q[SCORE_W-2:0], 1'b0};
            iter_d = iter_q + 4'd1;
        end
        if (done_en) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                dig_d[i] = bcd_q[i*4 +: 4];
            end
            busy_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_val_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            dig_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            last_val_q <= last_val_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            dig_q      <= dig_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [1:0]         scan_q, scan_d;
    logic [NUM_DIG-1:0] anodos_q, anodos_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         sel_dig;
    logic [6:0]         seg_dec;
    logic               nz1, nz2, nz3;
    logic               blank;

    // A digit is significant if it or any digit above it is nonzero.
    assign nz3 = |dig_q[3];
    assign nz2 = nz3 | (|dig_q[2]);
    assign nz1 = nz2 | (|dig_q[1]);

    assign sel_dig = dig_q[scan_q];

    decodificador_7seg u_dec (
        .digito_i    (sel_dig),
        .segmentos_o (seg_dec)
    );

    // Refresh divider, scan index and the registered anode/segment pair.
    always_comb begin
        ref_cnt_d = ref_cnt_q + CNT_W'(1);
        scan_d    = scan_q;
        if (ref_cnt_q == CNT_LAST) begin
            ref_cnt_d = '0;
            scan_d    = scan_q + 2'd1;
        end
        blank = 1'b0;
        case (scan_q)
            2'd1:    blank = !nz1;
            2'd2:    blank = !nz2;
            2'd3:    blank = !nz3;
            default: blank = 1'b0;
        endcase
        anodos_d = ~(NUM_DIG'(1) << scan_q);
        seg_d    = blank ? SEG_BLANK : seg_dec;
    end

    // Anodes and segments register together so they always match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            scan_q    <= '0;
            anodos_q  <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            scan_q    <= scan_d;
            anodos_q  <= anodos_d;
            seg_q     <= seg_d;
        end
    end

    assign anodos    = anodos_q;
    assign segmentos = seg_q;

endmodule

// File: tb/tb_display_puntuacion.sv
// Randomized bench for display_puntuacion against a decimal-arithmetic model.
module tb_display_puntuacion;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] puntuacion = '0;
    logic [3:0]  anodos;
    logic [6:0]  segmentos;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seg_t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

    display_puntuacion #(.REFRESH_DIV(RD), .SCORE_MAX(9999)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .puntuacion (puntuacion),
        .anodos     (anodos),
        .segmentos  (segmentos),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: saturate, then pick the decimal digit for position k.
    function automatic logic [6:0] exp_seg(input int v, input int k);
        int s, pw;
        s  = (v > 9999) ? 9999 : v;
        pw = 1;
        for (int i = 0; i < k; i++) pw = pw * 10;
        if (k > 0 && s < pw) return 7'b1111111;
        return seg_t[(s / pw) % 10];
    endfunction

    task automatic check_disp(input string tag, input int v, output int idx);
        logic [3:0] one;
        idx = -1;
        for (int k = 0; k < 4; k++) begin
            one = 4'b0001 << k;
            if (anodos == ~one) idx = k;
        end
        chk({tag, "_anodo1hot"}, 32'(idx >= 0), 1);
        if (idx >= 0) chk(tag, 32'(segmentos), 32'(exp_seg(v, idx)));
    endtask

    // Count negedges until busy reaches lvl; display must hold value v meanwhile.
    task automatic wait_busy(input logic lvl, input int maxn, input int v, output int n);
        int idx;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (busy === lvl) break;
            check_disp("hold", v, idx);
            if (n >= maxn) begin
                chk("busy_timeout", 32'(busy), 32'(lvl));
                break;
            end
        end
    endtask

    // Idle scan: busy low, digits per model, order 0..3, RD cycles each.
    task automatic scan_check(input int v, input int ncyc);
        int idx, prev, dw;
        bit first;
        prev = -1; dw = 0; first = 1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            check_disp("scan", v, idx);
            if (idx < 0) continue;
            if (prev < 0) begin
                prev = idx; dw = 1;
            end else if (idx == prev) begin
                dw++;
                if (dw > RD) chk("scan_dwell_long", dw, RD);
            end else begin
                chk("scan_order", idx, (prev + 1) % 4);
                if (!first) chk("scan_dwell", dw, RD);
                first = 0; prev = idx; dw = 1;
            end
        end
        chk("scan_moved", 32'(!first), 1);
    endtask

    task automatic finish_conv(input int old_v, input int new_v);
        int n;
        wait_busy(1'b1, 8, old_v, n);
        chk("busy_rise_lat", n, 2);
        wait_busy(1'b0, 40, old_v, n);
        chk("busy_width", n, 15);
        @(negedge clk);
        scan_check(new_v, 4 * RD + 2);
    endtask

    task automatic convert(input int old_v, input int new_v);
        @(negedge clk);
        puntuacion = 14'(new_v);
        finish_conv(old_v, new_v);
    endtask

    initial begin
        int n, idx, prev_v, v;

        // Reset held
        repeat (3) @(negedge clk);
        chk("rst_anodos", 32'(anodos), 32'hF);
        chk("rst_seg", 32'(segmentos), 32'h7F);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_anodo0", 32'(anodos), 32'b1110);
        chk("rel_seg0", 32'(segmentos), 32'b1000000);
        scan_check(0, 4 * RD + 2);

        convert(0, 1234);
        convert(1234, 105);
        convert(105, 12000);
        scan_check(12000, 40);   // constant out-of-range input: no retrigger

        // Change during SHIFT is ignored, then picked up afterwards
        @(negedge clk);
        puntuacion = 14'd42;
        wait_busy(1'b1, 8, 12000, n);
        chk("mid_rise_lat", n, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_disp("mid_hold", 12000, idx);
        end
        puntuacion = 14'd7;
        wait_busy(1'b0, 40, 12000, n);
        chk("mid_busy_width", n + 5, 15);
        @(negedge clk);
        chk("mid_gap_busy", 32'(busy), 0);
        check_disp("mid_shows42", 42, idx);
        @(negedge clk);
        chk("mid_restart", 32'(busy), 1);
        wait_busy(1'b0, 40, 42, n);
        chk("mid_busy2_width", n, 15);
        @(negedge clk);
        scan_check(7, 4 * RD + 2);

        // Reset in the middle of a conversion
        @(negedge clk);
        puntuacion = 14'd9999;
        wait_busy(1'b1, 8, 7, n);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_anodos", 32'(anodos), 32'hF);
        chk("midrst_seg", 32'(segmentos), 32'h7F);
        chk("midrst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        chk("midrst_hold_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        finish_conv(0, 9999);

        // Random scores, biased toward in-range and small values
        prev_v = 9999;
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 16383);
                1: v = $urandom_range(0, 99);
                2: v = prev_v;
                default: v = $urandom_range(0, 9999);
            endcase
            if (v == prev_v) begin
                @(negedge clk);
                puntuacion = 14'(v);
                scan_check(v, 20);
            end else begin
                convert(prev_v, v);
            end
            prev_v = v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
